// File: rtl/rca_wb_sequencer.sv
// Serialises multi-result RCA writebacks onto one register-file write port,
// buffering whole bursts in a small FIFO and committing each burst in order.
module rca_wb_sequencer #(
    parameter int unsigned NUM_WRITE_PORTS = 5,
    parameter int unsigned XLEN            = 32,
    parameter int unsigned ID_W            = 3,
    parameter int unsigned REG_ADDR_W      = 5,
    parameter int unsigned FIFO_DEPTH      = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  wb_done,
    input  logic [ID_W-1:0]                       wb_id,
    input  logic [NUM_WRITE_PORTS*XLEN-1:0]       wb_rd,
    input  logic [NUM_WRITE_PORTS*REG_ADDR_W-1:0] wb_dest_addrs,
    input  logic [NUM_WRITE_PORTS-1:0]            wb_dest_en,
    output logic                                  unit_ready,
    output logic                                  rf_we,
    output logic [REG_ADDR_W-1:0]                 rf_waddr,
    output logic [XLEN-1:0]                       rf_wdata,
    output logic [ID_W-1:0]                       rf_wid,
    input  logic                                  rf_stall,
    output logic                                  commit_valid,
    output logic [ID_W-1:0]                       commit_id,
    output logic                                  overflow_err
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned IDX_W = (NUM_WRITE_PORTS > 1) ? $clog2(NUM_WRITE_PORTS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Burst storage
    logic [ID_W-1:0]                       fifo_id    [FIFO_DEPTH];
    logic [NUM_WRITE_PORTS*XLEN-1:0]       fifo_rd    [FIFO_DEPTH];
    logic [NUM_WRITE_PORTS*REG_ADDR_W-1:0] fifo_addrs [FIFO_DEPTH];
    logic [NUM_WRITE_PORTS-1:0]            fifo_en    [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    state_t                     state;
    logic [NUM_WRITE_PORTS-1:0] mask;

    logic                                  full;
    logic                                  push;
    logic                                  pop;
    logic [ID_W-1:0]                       head_id;
    logic [NUM_WRITE_PORTS*XLEN-1:0]       head_rd;
    logic [NUM_WRITE_PORTS*REG_ADDR_W-1:0] head_addrs;
    logic [NUM_WRITE_PORTS-1:0]            head_en;
    logic [NUM_WRITE_PORTS-1:0]            head_mask;
    logic [NUM_WRITE_PORTS-1:0]            mask_cleared;
    logic [IDX_W-1:0]                      load_idx;
    logic [IDX_W-1:0]                      next_idx;
    logic [REG_ADDR_W-1:0]                 load_addr;
    logic [XLEN-1:0]                       load_data;
    logic [REG_ADDR_W-1:0]                 next_addr;
    logic [XLEN-1:0]                       next_data;

    // Index of the lowest set bit (0 when none set)
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_WRITE_PORTS-1:0] m);
        lowest_idx = '0;
        for (int i = int'(NUM_WRITE_PORTS) - 1; i >= 0; i--) begin
            if (m[i]) lowest_idx = IDX_W'(i);
        end
    endfunction

    assign full       = (count == CNT_W'(FIFO_DEPTH));
    assign unit_ready = !full;
    assign push       = wb_done && !full;
    assign pop        = (state == COMMIT);

    assign head_id    = fifo_id[rd_ptr];
    assign head_rd    = fifo_rd[rd_ptr];
    assign head_addrs = fifo_addrs[rd_ptr];
    assign head_en    = fifo_en[rd_ptr];

    // Writes to x0 are dropped up front so they cost no drain cycle
    always_comb begin
        head_mask = '0;
        for (int i = 0; i < int'(NUM_WRITE_PORTS); i++) begin
            head_mask[i] = head_en[i] && (head_addrs[i*REG_ADDR_W +: REG_ADDR_W] != '0);
        end
    end

    assign mask_cleared = mask & (mask - NUM_WRITE_PORTS'(1));
    assign load_idx     = lowest_idx(head_mask);
    assign next_idx     = lowest_idx(mask_cleared);

    // Select address/data for the first write of a burst and for the write after the current one
    always_comb begin
        load_addr = '0;
        load_data = '0;
        next_addr = '0;
        next_data = '0;
        for (int i = 0; i < int'(NUM_WRITE_PORTS); i++) begin
            if (IDX_W'(i) == load_idx) begin
                load_addr = head_addrs[i*REG_ADDR_W +: REG_ADDR_W];
                load_data = head_rd[i*XLEN +: XLEN];
            end
            if (IDX_W'(i) == next_idx) begin
                next_addr = head_addrs[i*REG_ADDR_W +: REG_ADDR_W];
                next_data = head_rd[i*XLEN +: XLEN];
            end
        end
    end

    // Payload capture; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id[wr_ptr]    <= wb_id;
            fifo_rd[wr_ptr]    <= wb_rd;
            fifo_addrs[wr_ptr] <= wb_dest_addrs;
            fifo_en[wr_ptr]    <= wb_dest_en;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (!push && pop) count <= count - CNT_W'(1);
            if (wb_done && full) overflow_err <= 1'b1;
        end
    end

    // Drain sequencer with registered write-port and commit outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            mask         <= '0;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            rf_wid       <= '0;
            commit_valid <= 1'b0;
            commit_id    <= '0;
        end else begin
            commit_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state <= DRAIN;
                        mask  <= head_mask;
                        rf_we <= |head_mask;
                        if (|head_mask) begin
                            rf_waddr <= load_addr;
                            rf_wdata <= load_data;
                            rf_wid   <= head_id;
                        end else begin
                            rf_waddr <= '0;
                            rf_wdata <= '0;
                            rf_wid   <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (mask == '0) begin
                        state        <= COMMIT;
                        commit_valid <= 1'b1;
                        commit_id    <= head_id;
                    end else if (!rf_stall) begin
                        mask <= mask_cleared;
                        if (mask_cleared == '0) begin
                            state        <= COMMIT;
                            commit_valid <= 1'b1;
                            commit_id    <= head_id;
                            rf_we        <= 1'b0;
                            rf_waddr     <= '0;
                            rf_wdata     <= '0;
                            rf_wid       <= '0;
                        end else begin
                            rf_waddr <= next_addr;
                            rf_wdata <= next_data;
                        end
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
